// File: rtl/linreg_seq_if.sv
// Handshake and coefficient bus for linreg_seq_unit: x in, y = w*x + b out.
interface linreg_seq_if #(
  parameter int unsigned WIDTH = 16
);
  logic                 coef_we;
  logic [WIDTH-1:0]     coef_w;
  logic [WIDTH-1:0]     coef_b;
  logic                 in_valid;
  logic                 in_ready;
  logic [WIDTH-1:0]     x;
  logic                 out_valid;
  logic                 out_ready;
  logic [2*WIDTH-1:0]   y;

  modport master (
    output coef_we, coef_w, coef_b, in_valid, x, out_ready,
    input  in_ready, out_valid, y
  );

  modport slave (
    input  coef_we, coef_w, coef_b, in_valid, x, out_ready,
    output in_ready, out_valid, y
  );
endinterface

// File: rtl/linreg_seq_unit.sv
// Sequential linear regression unit: y = w*x + b via WIDTH-cycle shift-add multiply.
// Define LINREG_SIGNED_EN for two's complement operands (default: unsigned).
module linreg_seq_unit #(
  parameter int unsigned      WIDTH  = 16,
  parameter logic [WIDTH-1:0] W_INIT = WIDTH'(10000),
  parameter logic [WIDTH-1:0] B_INIT = WIDTH'(10000)
) (
  input  logic         clk,
  input  logic         rst,
  linreg_seq_if.slave  bus
);

  localparam int unsigned ACC_W = 2 * WIDTH;
  localparam int unsigned CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    MUL  = 2'd1,
    ADD  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t             state;
  logic [WIDTH-1:0]   w_q;
  logic [WIDTH-1:0]   b_q;
  logic [WIDTH-1:0]   x_sr;
  logic [WIDTH-1:0]   w_mag;
  logic               neg_q;
  logic [ACC_W-1:0]   acc;
  logic [CNT_W-1:0]   cnt;
  logic [ACC_W-1:0]   y_q;
  logic               in_ready_q;
  logic               out_valid_q;

  logic [WIDTH-1:0]   w_eff_c;
  logic [WIDTH-1:0]   x_mag_c;
  logic [WIDTH-1:0]   w_mag_c;
  logic               neg_c;
  logic [ACC_W-1:0]   b_ext_c;
  logic [ACC_W-1:0]   prod_c;

  // Operand conditioning; a coincident coefficient write feeds the new slope straight in.
  always_comb begin
    w_eff_c = bus.coef_we ? bus.coef_w : w_q;
`ifdef LINREG_SIGNED_EN
    x_mag_c = bus.x[WIDTH-1]   ? WIDTH'(~bus.x + 1'b1)   : bus.x;
    w_mag_c = w_eff_c[WIDTH-1] ? WIDTH'(~w_eff_c + 1'b1) : w_eff_c;
    neg_c   = bus.x[WIDTH-1] ^ w_eff_c[WIDTH-1];
    b_ext_c = {{WIDTH{b_q[WIDTH-1]}}, b_q};
    prod_c  = neg_q ? ACC_W'(~acc + 1'b1) : acc;
`else
    x_mag_c = bus.x;
    w_mag_c = w_eff_c;
    neg_c   = 1'b0;
    b_ext_c = {{WIDTH{1'b0}}, b_q};
    prod_c  = acc;
`endif
  end

  // Control FSM and datapath
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      w_q         <= W_INIT;
      b_q         <= B_INIT;
      x_sr        <= '0;
      w_mag       <= '0;
      neg_q       <= 1'b0;
      acc         <= '0;
      cnt         <= '0;
      y_q         <= '0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.coef_we) begin
            w_q <= bus.coef_w;
            b_q <= bus.coef_b;
          end
          if (bus.in_valid) begin
            x_sr       <= x_mag_c;
            w_mag      <= w_mag_c;
            neg_q      <= neg_c;
            acc        <= '0;
            cnt        <= '0;
            in_ready_q <= 1'b0;
            state      <= MUL;
          end
        end
        MUL: begin
          // One partial product per cycle, always WIDTH cycles regardless of x.
          if (x_sr[0]) begin
            acc <= acc + (ACC_W'(w_mag) << cnt);
          end
          x_sr <= x_sr >> 1;
          cnt  <= cnt + 1'b1;
          if (cnt == CNT_W'(WIDTH - 1)) begin
            state <= ADD;
          end
        end
        ADD: begin
          y_q   <= prod_c + b_ext_c;
          state <= DONE;
        end
        DONE: begin
          if (!out_valid_q) begin
            out_valid_q <= 1'b1;
          end else if (bus.out_ready) begin
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state       <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.y         = y_q;

endmodule

// File: tb/tb_linreg_seq_unit.sv
// Directed scoreboard bench for linreg_seq_unit (WIDTH=16); signed vectors under LINREG_SIGNED_EN.
module tb_linreg_seq_unit;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  linreg_seq_if #(.WIDTH(16)) bus();

  linreg_seq_unit #(.WIDTH(16)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          acc_cyc = 0;
  logic [31:0] sb[$];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] model(input logic [15:0] w, input logic [15:0] b,
                                        input logic [15:0] xv);
`ifdef LINREG_SIGNED_EN
    logic signed [31:0] ws, bs, xs;
    ws = 32'($signed(w));
    bs = 32'($signed(b));
    xs = 32'($signed(xv));
    return 32'(ws * xs + bs);
`else
    return ({16'b0, w} * {16'b0, xv}) + {16'b0, b};
`endif
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Present x (optionally with a coincident coefficient write) and push the expected y.
  task automatic start(input logic [15:0] xv, input bit wr, input logic [15:0] wv,
                       input logic [15:0] bv, input logic [31:0] exp);
    chk("in_ready_idle", 32'(bus.in_ready), 32'd1);
    bus.x        = xv;
    bus.in_valid = 1'b1;
    bus.coef_we  = wr;
    bus.coef_w   = wv;
    bus.coef_b   = bv;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    acc_cyc      = cyc;
    sb.push_back(exp);
  endtask

  // Wait for the result, compare against the scoreboard, optionally hold backpressure.
  task automatic finish(input string tag, input int hold);
    int          n;
    logic [31:0] exp;
    n = 0;
    while (!bus.out_valid && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk({tag, "_latency"}, 32'(cyc - acc_cyc), 32'd18);
    exp = (sb.size() > 0) ? sb.pop_front() : 32'hDEAD_BEEF;
    chk(tag, bus.y, exp);
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      chk({tag, "_hold_y"}, bus.y, exp);
      chk({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      chk({tag, "_hold_ready"}, 32'(bus.in_ready), 32'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    chk({tag, "_release_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_release_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_release_y"}, bus.y, exp);
  endtask

  task automatic set_coef(input logic [15:0] wv, input logic [15:0] bv);
    bus.coef_we = 1'b1;
    bus.coef_w  = wv;
    bus.coef_b  = bv;
    @(posedge clk);
    #1;
    bus.coef_we = 1'b0;
  endtask

  initial begin
    logic [15:0] rw, rb, rx;
    bit          seen;

    // Reset with competing coef_we / in_valid, which must lose.
    rst           = 1'b1;
    bus.coef_we   = 1'b1;
    bus.coef_w    = 16'd2;
    bus.coef_b    = 16'd5;
    bus.in_valid  = 1'b1;
    bus.x         = 16'd5;
    bus.out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst          = 1'b0;
    bus.in_valid = 1'b0;
    bus.coef_we  = 1'b0;
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_y", bus.y, 32'd0);

    // Default coefficients: 10000*3 + 10000.
    start(16'd3, 1'b0, 16'd0, 16'd0, 32'd40000);
    finish("x3_default", 0);

    // Coefficient write during MUL must not disturb the in-flight result or persist.
    set_coef(16'd2, 16'd5);
    start(16'd7, 1'b0, 16'd0, 16'd0, 32'd19);
    repeat (3) @(posedge clk);
    #1;
    bus.coef_we = 1'b1;
    bus.coef_w  = 16'd100;
    bus.coef_b  = 16'd5;
    @(posedge clk);
    #1;
    bus.coef_we = 1'b0;
    finish("inflight", 0);
    start(16'd1, 1'b0, 16'd0, 16'd0, 32'd7);
    finish("mul_write_ignored", 0);
    start(16'd1, 1'b1, 16'd100, 16'd5, 32'd105);
    finish("coincident_write", 0);

    // All-ones operands.
`ifdef LINREG_SIGNED_EN
    start(16'hFFFF, 1'b1, 16'hFFFF, 16'hFFFF, 32'h0000_0000);
`else
    start(16'hFFFF, 1'b1, 16'hFFFF, 16'hFFFF, 32'hFFFF_0000);
`endif
    finish("all_ones", 0);

    // Backpressure for 5 cycles.
    bus.out_ready = 1'b0;
    start(16'd5, 1'b1, 16'd3, 16'd4, 32'd19);
    finish("backpressure", 5);

`ifdef LINREG_SIGNED_EN
    start(16'd4, 1'b1, 16'hFFFD, 16'd10, 32'hFFFF_FFFE);
    finish("signed_neg", 0);
    start(16'h8000, 1'b1, 16'h8000, 16'd0, 32'h4000_0000);
    finish("signed_min", 0);
`endif

    // Pseudo-random vectors against the reference model.
    for (int i = 0; i < 3; i++) begin
      rw = 16'($urandom_range(0, 16'hFFFF));
      rb = 16'($urandom_range(0, 16'hFFFF));
      rx = 16'($urandom_range(0, 16'hFFFF));
      start(rx, 1'b1, rw, rb, model(rw, rb, rx));
      finish("random", 0);
    end

    // Reset during MUL cycle 7 aborts the operation and restores coefficients.
    start(16'h1234, 1'b1, 16'd2, 16'd5, model(16'd2, 16'd5, 16'h1234));
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    void'(sb.pop_back());
    seen = 1'b0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) seen = 1'b1;
    end
    chk("abort_no_valid", 32'(seen), 32'd0);
    start(16'd0, 1'b0, 16'd0, 16'd0, 32'd10000);
    finish("x0_after_reset", 0);
    start(16'd1, 1'b0, 16'd0, 16'd0, 32'd20000);
    finish("w_after_reset", 0);

    chk("scoreboard_empty", 32'(sb.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
